// File: rtl/pp_pkg.sv
// Shared definitions for the pipelined processor slice: fetch FSM state,
// bubble encoding, default PC width, opcodes used by the ID stage, and a
// sign-extension helper.
package pp_pkg;

  localparam int          PP_ADDR_W    = 5;
  localparam logic [31:0] PP_NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0]  OP_J   = 6'b000010;
  localparam logic [5:0]  OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // Sign-extend a 16-bit word offset to 32 bits.
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/next_pc_sel_pp.sv
// Combinational next-PC select for the fetch stage.
// Priority: stall (hold) > taken branch > jump > sequential PC+1.
// Redirect requests only count when the ID stage holds a real instruction.
module next_pc_sel_pp
  import pp_pkg::*;
#(
  parameter int ADDR_W = PP_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] ifid_pc1,
  input  logic              ifid_valid,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  output logic [ADDR_W-1:0] next_pc,
  output logic              advance,
  output logic              squash
);

  logic [31:0] branch_target_full;
  logic        unused_bits;

  // Branch target is computed at full width, then wraps to the PC width.
  assign branch_target_full = {{(32-ADDR_W){1'b0}}, ifid_pc1} + sext16(branch_offset);
  assign unused_bits = ^{branch_target_full[31:ADDR_W], jump_index[25:ADDR_W]};

  // Select the next PC and whether the fetch in flight is squashed.
  always_comb begin
    next_pc = pc;
    advance = 1'b0;
    squash  = 1'b0;
    if (stall) begin
      next_pc = pc;
    end else if (ifid_valid && branch_taken) begin
      next_pc = branch_target_full[ADDR_W-1:0];
      advance = 1'b1;
      squash  = 1'b1;
    end else if (ifid_valid && jump) begin
      next_pc = jump_index[ADDR_W-1:0];
      advance = 1'b1;
      squash  = 1'b1;
    end else begin
      next_pc = pc + ADDR_W'(1);
      advance = 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_pp.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// loads the IF/ID register. Optional perf counters under FETCH_PERF_EN.
//
// Flow control: Stall=1 freezes PC, IF/ID and Redirect; any redirect request
// seen during a stall is dropped and must be re-asserted by ID afterwards.
// A redirect (branch or jump with IFID_Valid=1) loads the target PC and
// replaces the wrong-path fetch with one bubble (IFID_Valid=0).
module pc_fetch_pp
  import pp_pkg::*;
#(
  parameter int          ADDR_W    = PP_ADDR_W,
  parameter int          RESET_PC  = 0,
  parameter logic [31:0] NOP_INSTR = PP_NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  output logic [31:0]  PC_Out,
  input  logic [31:0]  Instr_In,
  input  logic         Stall,
  input  logic         Branch_Taken,
  input  logic [15:0]  Branch_Offset,
  input  logic         Jump,
  input  logic [25:0]  Jump_Index,
  output logic [31:0]  IFID_Instr,
  output logic [31:0]  IFID_PC1,
  output logic         IFID_Valid,
  output logic         Redirect,
`ifdef FETCH_PERF_EN
  output logic [31:0]  Fetch_Count,
  output logic [31:0]  Flush_Count,
`endif
  output fetch_state_e fsm_state
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] ifid_pc1_q;
  logic [ADDR_W-1:0] next_pc;
  logic              advance;
  logic              squash;

  next_pc_sel_pp #(.ADDR_W(ADDR_W)) u_sel (
    .pc            (pc_q),
    .ifid_pc1      (ifid_pc1_q),
    .ifid_valid    (IFID_Valid),
    .stall         (Stall),
    .branch_taken  (Branch_Taken),
    .branch_offset (Branch_Offset),
    .jump          (Jump),
    .jump_index    (Jump_Index),
    .next_pc       (next_pc),
    .advance       (advance),
    .squash        (squash)
  );

  assign PC_Out   = {{(32-ADDR_W){1'b0}}, pc_q};
  assign IFID_PC1 = {{(32-ADDR_W){1'b0}}, ifid_pc1_q};

  // PC, IF/ID register, redirect pulse and fetch FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= ADDR_W'(RESET_PC);
      IFID_Instr <= NOP_INSTR;
      ifid_pc1_q <= '0;
      IFID_Valid <= 1'b0;
      Redirect   <= 1'b0;
      fsm_state  <= FILL;
    end else begin
      // HOLD tracks stall cycles only; the datapath is the same in RUN.
      fsm_state <= Stall ? HOLD : RUN;
      if (advance) begin
        pc_q     <= next_pc;
        Redirect <= squash;
        if (squash) begin
          IFID_Instr <= NOP_INSTR;
          ifid_pc1_q <= '0;
          IFID_Valid <= 1'b0;
        end else begin
          // On a sequential fetch next_pc is already PC+1 (wrapped).
          IFID_Instr <= Instr_In;
          ifid_pc1_q <= next_pc;
          IFID_Valid <= 1'b1;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters of valid IF/ID loads and of redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      Fetch_Count <= '0;
      Flush_Count <= '0;
    end else if (advance) begin
      if (!squash && Fetch_Count != 32'hFFFF_FFFF) Fetch_Count <= Fetch_Count + 32'd1;
      if (squash && Flush_Count != 32'hFFFF_FFFF) Flush_Count <= Flush_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_pp.sv
// Self-checking bench for pc_fetch_pp: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_pp;
  import pp_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  PC_Out;
  logic [31:0]  Instr_In;
  logic         Stall;
  logic         Branch_Taken;
  logic [15:0]  Branch_Offset;
  logic         Jump;
  logic [25:0]  Jump_Index;
  logic [31:0]  IFID_Instr;
  logic [31:0]  IFID_PC1;
  logic         IFID_Valid;
  logic         Redirect;
  fetch_state_e fsm_state;
`ifdef FETCH_PERF_EN
  logic [31:0]  Fetch_Count;
  logic [31:0]  Flush_Count;
`endif

  pc_fetch_pp dut (
    .clk           (clk),
    .rst           (rst),
    .PC_Out        (PC_Out),
    .Instr_In      (Instr_In),
    .Stall         (Stall),
    .Branch_Taken  (Branch_Taken),
    .Branch_Offset (Branch_Offset),
    .Jump          (Jump),
    .Jump_Index    (Jump_Index),
    .IFID_Instr    (IFID_Instr),
    .IFID_PC1      (IFID_PC1),
    .IFID_Valid    (IFID_Valid),
    .Redirect      (Redirect),
`ifdef FETCH_PERF_EN
    .Fetch_Count   (Fetch_Count),
    .Flush_Count   (Flush_Count),
`endif
    .fsm_state     (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Combinational ROM contents, randomized once
  logic [31:0] rom [32];
  logic [4:0]  rom_addr;
  assign rom_addr = PC_Out[4:0];
  assign Instr_In = rom[rom_addr];

  // Reference model state
  int           m_pc, m_pc1, m_valid, m_redirect;
  logic [31:0]  m_instr;
  fetch_state_e m_state;
  longint       m_fetch, m_flush;

  int n_cmp = 0;
  int n_err = 0;

  // Apply the fetch rules to the model using the inputs as they stand, then clock.
  task automatic step();
    int t;
    if (rst) begin
      m_pc = 0; m_pc1 = 0; m_valid = 0; m_redirect = 0;
      m_instr = 32'h0; m_state = FILL; m_fetch = 0; m_flush = 0;
    end else begin
      m_state = Stall ? HOLD : RUN;
      if (!Stall) begin
        if (m_valid == 1 && (Branch_Taken || Jump)) begin
          if (Branch_Taken) begin
            t = m_pc1 + int'($signed(Branch_Offset));
            m_pc = ((t % 32) + 32) % 32;
          end else begin
            m_pc = int'(Jump_Index) % 32;
          end
          m_instr = 32'h0; m_pc1 = 0; m_valid = 0; m_redirect = 1;
          if (m_flush < 64'hFFFF_FFFF) m_flush++;
        end else begin
          m_instr = rom[m_pc];
          m_pc1 = (m_pc + 1) % 32;
          m_pc = m_pc1;
          m_valid = 1; m_redirect = 0;
          if (m_fetch < 64'hFFFF_FFFF) m_fetch++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Offset = 16'h0;
    Jump = 1'b0; Jump_Index = 26'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (PC_Out !== 32'd0) begin n_err++; $display("FAIL reset_pc got %0d exp 0", PC_Out); end
    n_cmp++; if (IFID_Instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0", IFID_Instr); end
    n_cmp++; if (IFID_PC1 !== 32'd0) begin n_err++; $display("FAIL reset_pc1 got %0d exp 0", IFID_PC1); end
    n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", IFID_Valid); end
    n_cmp++; if (Redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect got %b exp 0", Redirect); end
    n_cmp++; if (fsm_state !== FILL) begin n_err++; $display("FAIL reset_state got %0d exp FILL", fsm_state); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (PC_Out !== 32'(i)) begin n_err++; $display("FAIL run_pc got %0d exp %0d", PC_Out, i); end
      n_cmp++; if (IFID_PC1 !== 32'(i)) begin n_err++; $display("FAIL run_pc1 got %0d exp %0d", IFID_PC1, i); end
      n_cmp++; if (IFID_Valid !== 1'b1) begin n_err++; $display("FAIL run_valid got %b exp 1", IFID_Valid); end
      n_cmp++; if (IFID_Instr !== rom[i-1]) begin n_err++; $display("FAIL run_instr got %h exp %h", IFID_Instr, rom[i-1]); end
      n_cmp++; if (fsm_state !== RUN) begin n_err++; $display("FAIL run_state got %0d exp RUN", fsm_state); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (8) step();
    Branch_Taken = 1'b1; Branch_Offset = 16'd6;
    step();
    Branch_Taken = 1'b0;
    n_cmp++; if (PC_Out !== 32'd14) begin n_err++; $display("FAIL br_pc got %0d exp 14", PC_Out); end
    n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL br_valid got %b exp 0", IFID_Valid); end
    n_cmp++; if (IFID_Instr !== 32'h0) begin n_err++; $display("FAIL br_instr got %h exp 0", IFID_Instr); end
    n_cmp++; if (Redirect !== 1'b1) begin n_err++; $display("FAIL br_redirect got %b exp 1", Redirect); end
    step();
    n_cmp++; if (IFID_PC1 !== 32'd15) begin n_err++; $display("FAIL br_pc1 got %0d exp 15", IFID_PC1); end
    n_cmp++; if (Redirect !== 1'b0) begin n_err++; $display("FAIL br_redirect_clr got %b exp 0", Redirect); end
    n_cmp++; if (IFID_Instr !== rom[14]) begin n_err++; $display("FAIL br_target_instr got %h exp %h", IFID_Instr, rom[14]); end
  endtask

  task automatic test_jump();
    Jump = 1'b1; Jump_Index = 26'h1C;
    step();
    Jump = 1'b0;
    n_cmp++; if (PC_Out !== 32'd28) begin n_err++; $display("FAIL jmp_pc got %0d exp 28", PC_Out); end
    n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL jmp_valid got %b exp 0", IFID_Valid); end
    n_cmp++; if (Redirect !== 1'b1) begin n_err++; $display("FAIL jmp_redirect got %b exp 1", Redirect); end
    // Redirect with a bubble in ID must be ignored.
    Jump = 1'b1; Jump_Index = 26'h3;
    step();
    Jump = 1'b0;
    n_cmp++; if (PC_Out !== 32'd29) begin n_err++; $display("FAIL jmp_bubble_pc got %0d exp 29", PC_Out); end
    do_reset();
    repeat (3) step();
    Branch_Taken = 1'b1; Branch_Offset = 16'hFFFE;
    step();
    Branch_Taken = 1'b0;
    n_cmp++; if (PC_Out !== 32'd1) begin n_err++; $display("FAIL neg_br_pc got %0d exp 1", PC_Out); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (17) step();
    Stall = 1'b1; Branch_Taken = 1'b1; Branch_Offset = 16'(($urandom_range(1, 9)));
    repeat (2) begin
      step();
      n_cmp++; if (PC_Out !== 32'd17) begin n_err++; $display("FAIL stall_pc got %0d exp 17", PC_Out); end
      n_cmp++; if (IFID_PC1 !== 32'd17) begin n_err++; $display("FAIL stall_pc1 got %0d exp 17", IFID_PC1); end
      n_cmp++; if (IFID_Instr !== rom[16]) begin n_err++; $display("FAIL stall_instr got %h exp %h", IFID_Instr, rom[16]); end
      n_cmp++; if (IFID_Valid !== 1'b1) begin n_err++; $display("FAIL stall_valid got %b exp 1", IFID_Valid); end
      n_cmp++; if (fsm_state !== HOLD) begin n_err++; $display("FAIL stall_state got %0d exp HOLD", fsm_state); end
    end
    Stall = 1'b0; Branch_Taken = 1'b0;
    step();
    n_cmp++; if (PC_Out !== 32'd18) begin n_err++; $display("FAIL unstall_pc got %0d exp 18", PC_Out); end
    n_cmp++; if (fsm_state !== RUN) begin n_err++; $display("FAIL unstall_state got %0d exp RUN", fsm_state); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    repeat (31) step();
    n_cmp++; if (PC_Out !== 32'd31) begin n_err++; $display("FAIL pre_wrap_pc got %0d exp 31", PC_Out); end
    step();
    n_cmp++; if (PC_Out !== 32'd0) begin n_err++; $display("FAIL wrap_pc got %0d exp 0", PC_Out); end
    n_cmp++; if (IFID_PC1 !== 32'd0) begin n_err++; $display("FAIL wrap_pc1 got %0d exp 0", IFID_PC1); end
    n_cmp++; if (IFID_Instr !== rom[31]) begin n_err++; $display("FAIL wrap_instr got %h exp %h", IFID_Instr, rom[31]); end
    repeat (2) step();
    Stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; Stall = 1'b0;
    n_cmp++; if (PC_Out !== 32'd0) begin n_err++; $display("FAIL stall_rst_pc got %0d exp 0", PC_Out); end
    n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL stall_rst_valid got %b exp 0", IFID_Valid); end
    n_cmp++; if (IFID_PC1 !== 32'd0) begin n_err++; $display("FAIL stall_rst_pc1 got %0d exp 0", IFID_PC1); end
    n_cmp++; if (IFID_Instr !== 32'h0) begin n_err++; $display("FAIL stall_rst_instr got %h exp 0", IFID_Instr); end
    n_cmp++; if (fsm_state !== FILL) begin n_err++; $display("FAIL stall_rst_state got %0d exp FILL", fsm_state); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    n_cmp++; if (Fetch_Count !== 32'd0) begin n_err++; $display("FAIL perf_rst_fetch got %0d exp 0", Fetch_Count); end
    repeat (5) step();
    Branch_Taken = 1'b1; Branch_Offset = 16'd3;
    step();
    Branch_Taken = 1'b0;
    n_cmp++; if (Fetch_Count !== 32'd5) begin n_err++; $display("FAIL perf_fetch got %0d exp 5", Fetch_Count); end
    n_cmp++; if (Flush_Count !== 32'd1) begin n_err++; $display("FAIL perf_flush got %0d exp 1", Flush_Count); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 39) == 0);
      Stall         = ($urandom_range(0, 4) == 0);
      Branch_Taken  = ($urandom_range(0, 3) == 0);
      Jump          = ($urandom_range(0, 3) == 0);
      Branch_Offset = 16'($urandom);
      Jump_Index    = 26'($urandom);
      step();
      n_cmp++; if (PC_Out !== 32'(m_pc)) begin n_err++; $display("FAIL rand_pc c=%0d got %0d exp %0d", c, PC_Out, m_pc); end
      n_cmp++; if (IFID_PC1 !== 32'(m_pc1)) begin n_err++; $display("FAIL rand_pc1 c=%0d got %0d exp %0d", c, IFID_PC1, m_pc1); end
      n_cmp++; if (IFID_Instr !== m_instr) begin n_err++; $display("FAIL rand_instr c=%0d got %h exp %h", c, IFID_Instr, m_instr); end
      n_cmp++; if (IFID_Valid !== 1'(m_valid)) begin n_err++; $display("FAIL rand_valid c=%0d got %b exp %0d", c, IFID_Valid, m_valid); end
      n_cmp++; if (Redirect !== 1'(m_redirect)) begin n_err++; $display("FAIL rand_redirect c=%0d got %b exp %0d", c, Redirect, m_redirect); end
      n_cmp++; if (fsm_state !== m_state) begin n_err++; $display("FAIL rand_state c=%0d got %0d exp %0d", c, fsm_state, m_state); end
`ifdef FETCH_PERF_EN
      n_cmp++; if (Fetch_Count !== 32'(m_fetch)) begin n_err++; $display("FAIL rand_fetch c=%0d got %0d exp %0d", c, Fetch_Count, m_fetch); end
      n_cmp++; if (Flush_Count !== 32'(m_flush)) begin n_err++; $display("FAIL rand_flush c=%0d got %0d exp %0d", c, Flush_Count, m_flush); end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    idle_inputs();
    m_pc = 0; m_pc1 = 0; m_valid = 0; m_redirect = 0;
    m_instr = 32'h0; m_state = FILL; m_fetch = 0; m_flush = 0;
    @(negedge clk);
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_wrap_and_reset();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
